// File: rtl/trena_pkg.sv
// trena_pkg
// Shared definitions for the trena ultrasonic datapath.
//   - estado_t      : state encodings of interface_hcsr04 (value = db_estado code)
//   - DEF_*         : default timing constants for a 50 MHz clock
//   - BCD_WIDTH     : width of the three-digit BCD distance
//   - bcd_next()    : increments a three-digit BCD value with per-digit carry
package trena_pkg;

  localparam int BCD_WIDTH          = 12;
  localparam int DEF_TRIGGER_CYCLES = 500;        // 10 us
  localparam int DEF_CYCLES_PER_CM  = 2941;       // 58.82 us
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;  // 30 ms

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDINDO       = 4'h4,
    ARMAZENA      = 4'h5,
    FINAL_MEDIDA  = 4'h6,
    ERRO_TIMEOUT  = 4'hE
  } estado_t;

  // Each digit rolls 9 -> 0 and carries into the next one. The caller is
  // responsible for not calling this on 999.
  function automatic logic [BCD_WIDTH-1:0] bcd_next(input logic [BCD_WIDTH-1:0] v);
    logic [BCD_WIDTH-1:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_bcd_3dig.sv
// contador_bcd_3dig
// Three-digit BCD up-counter that saturates at 999.
// Ports:
//   clock  in  : system clock
//   reset  in  : asynchronous active-high reset (valor -> 000)
//   zera   in  : synchronous clear, has priority over conta
//   conta  in  : increment by one when not already at 999
//   valor  out : current count, [11:8] centena, [7:4] dezena, [3:0] unidade
module contador_bcd_3dig
  import trena_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 zera,
  input  logic                 conta,
  output logic [BCD_WIDTH-1:0] valor
);

  localparam logic [BCD_WIDTH-1:0] VALOR_MAX = 12'h999;

  // Once 999 is reached further increments are dropped, so an over-range
  // echo reads as the maximum distance instead of wrapping to a small one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta && (valor != VALOR_MAX)) begin
      valor <= bcd_next(valor);
    end
  end

endmodule

// File: rtl/interface_hcsr04.sv
// interface_hcsr04
// HC-SR04 front-end: on medir it fires the trigger pulse, times the echo
// pulse and converts its width to whole centimetres as three BCD digits.
// Optional watchdog: define HCSR04_TIMEOUT_EN to abort a measurement that
// spends TIMEOUT_CYCLES clocks waiting for / measuring the echo.
// Ports:
//   clock     in  : system clock
//   reset     in  : asynchronous active-high reset
//   medir     in  : start request, only looked at in INICIAL
//   echo      in  : sensor echo (asynchronous)
//   trigger   out : sensor trigger pulse, TRIGGER_CYCLES clocks wide
//   medida    out : BCD distance in cm
//   pronto    out : one-cycle strobe, new medida valid
//   erro      out : one-cycle strobe, watchdog expired
//   db_estado out : current state code (F for an illegal encoding)
module interface_hcsr04
  import trena_pkg::*;
#(
  parameter int TRIGGER_CYCLES = DEF_TRIGGER_CYCLES,
  parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 medir,
  input  logic                 echo,
  output logic                 trigger,
  output logic [BCD_WIDTH-1:0] medida,
  output logic                 pronto,
  output logic                 erro,
  output logic [3:0]           db_estado
);

  localparam int TRIG_W = $clog2(TRIGGER_CYCLES + 1);
  localparam int DIV_W  = $clog2(CYCLES_PER_CM + 1);
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CYCLES_PER_CM - 1);

  estado_t                 state, next_state;
  logic                    echo_meta, echo_s;
  logic [TRIG_W-1:0]       trig_cnt;
  logic [DIV_W-1:0]        div_cnt;
  logic                    counting, cm_tick, timeout;
  logic [BCD_WIDTH-1:0]    acumulado;

  // Two-flop synchroniser; nothing downstream looks at the raw pin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
    end
  end

  // Echo-high cycles are counted in ESPERA_ECHO too, so an echo that is
  // already high when we start waiting is timed from that first cycle.
  assign counting = ((state == ESPERA_ECHO) || (state == MEDINDO)) && echo_s;
  assign cm_tick  = counting && (div_cnt == DIV_LAST);

`ifdef HCSR04_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt;

  // Watchdog counts every clock spent in ESPERA_ECHO or MEDINDO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == PREPARACAO) begin
      wd_cnt <= '0;
    end else if ((state == ESPERA_ECHO) || (state == MEDINDO)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = (wd_cnt == WD_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  // Trigger length counter and cm divider; both restart in PREPARACAO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      if (state == ENVIA_TRIGGER) trig_cnt <= trig_cnt + TRIG_W'(1);
      else                        trig_cnt <= '0;
      if (state == PREPARACAO)    div_cnt  <= '0;
      else if (cm_tick)           div_cnt  <= '0;
      else if (counting)          div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  contador_bcd_3dig u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (state == PREPARACAO),
    .conta (cm_tick),
    .valor (acumulado)
  );

  // medida only changes in ARMAZENA; trigger is registered from the state,
  // which delays it one clock but keeps it exactly TRIGGER_CYCLES wide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      medida  <= '0;
      trigger <= 1'b0;
    end else begin
      if (state == ARMAZENA) medida <= acumulado;
      trigger <= (state == ENVIA_TRIGGER);
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= next_state;
  end

  // Next-state logic; the watchdog wins over a simultaneous echo change.
  always_comb begin
    next_state = INICIAL;
    case (state)
      INICIAL:       next_state = medir ? PREPARACAO : INICIAL;
      PREPARACAO:    next_state = ENVIA_TRIGGER;
      ENVIA_TRIGGER: next_state = (trig_cnt == TRIG_LAST) ? ESPERA_ECHO : ENVIA_TRIGGER;
      ESPERA_ECHO: begin
        if (timeout)     next_state = ERRO_TIMEOUT;
        else if (echo_s) next_state = MEDINDO;
        else             next_state = ESPERA_ECHO;
      end
      MEDINDO: begin
        if (timeout)      next_state = ERRO_TIMEOUT;
        else if (!echo_s) next_state = ARMAZENA;
        else              next_state = MEDINDO;
      end
      ARMAZENA:      next_state = FINAL_MEDIDA;
      FINAL_MEDIDA:  next_state = INICIAL;
      ERRO_TIMEOUT:  next_state = INICIAL;
      default:       next_state = INICIAL;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    pronto    = (state == FINAL_MEDIDA);
`ifdef HCSR04_TIMEOUT_EN
    erro      = (state == ERRO_TIMEOUT);
`else
    erro      = 1'b0;
`endif
    db_estado = 4'hF;
    case (state)
      INICIAL, PREPARACAO, ENVIA_TRIGGER, ESPERA_ECHO, MEDINDO,
      ARMAZENA, FINAL_MEDIDA, ERRO_TIMEOUT: db_estado = state;
      default:                              db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_interface_hcsr04.sv
// tb_interface_hcsr04
// Bench for interface_hcsr04 with scaled-down timing parameters. Expected
// distances come from floor(cycles / CYCLES_PER_CM) clamped at 999 and
// written out digit by digit. The watchdog scenario runs only when
// HCSR04_TIMEOUT_EN is defined.
module tb_interface_hcsr04;

  localparam int TRIG = 5;
  localparam int CPCM = 7;
  localparam int TMO  = 8000;

  logic        clock = 1'b0;
  logic        reset, medir, echo;
  logic        trigger, pronto, erro;
  logic [11:0] medida;
  logic [3:0]  db_estado;
  int          total = 0;
  int          bad = 0;
  logic [11:0] last_medida;

  always #5 clock = ~clock;

  interface_hcsr04 #(
    .TRIGGER_CYCLES (TRIG),
    .CYCLES_PER_CM  (CPCM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .medida    (medida),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  // Reference: whole centimetres, clamped, then split into decimal digits.
  function automatic logic [11:0] refMedida(input int cycles);
    int cm;
    cm = cycles / CPCM;
    if (cm > 999) cm = 999;
    return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulses medir for one clock and checks trigger latency and width.
  // Returns at the first falling-edge sample where trigger is low again.
  task automatic applyStimulus();
    int lat, width;
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    lat = 1;
    while (!trigger && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("trig_latency", lat, 3);
    width = 0;
    while (trigger && width < TRIG + 20) begin
      @(negedge clock);
      width++;
    end
    checkOutput("trig_width", width, TRIG);
  endtask

  // One full measurement with echo high for n clock edges.
  task automatic measure(input int n, input bit poke);
    logic [11:0] exp;
    int lat;
    exp = refMedida(n);
    applyStimulus();
    repeat ($urandom_range(0, 4)) @(negedge clock);
    echo = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      medir = (poke && (i == n / 2)) ? 1'b1 : 1'b0;
    end
    echo  = 1'b0;
    medir = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!pronto && lat < 20);
    checkOutput("pronto_latency", lat, 4);
    checkOutput("medida", medida, exp);
    checkOutput("erro_with_pronto", erro, 0);
    @(negedge clock);
    checkOutput("pronto_width", pronto, 0);
    checkOutput("estado_after", db_estado, 0);
    checkOutput("medida_hold", medida, exp);
    last_medida = exp;
  endtask

  initial begin
    reset = 1'b1;
    medir = 1'b0;
    echo  = 1'b0;
    last_medida = 12'h000;
    repeat (3) @(negedge clock);
    checkOutput("rst_trigger", trigger, 0);
    checkOutput("rst_pronto", pronto, 0);
    checkOutput("rst_erro", erro, 0);
    checkOutput("rst_medida", medida, 12'h000);
    checkOutput("rst_estado", db_estado, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Directed boundaries around the cm divider.
    measure(50 * CPCM, 1'b0);
    measure(50 * CPCM - 1, 1'b1);
    measure(CPCM, 1'b0);
    measure(CPCM - 1, 1'b0);

    // Random widths, some with a stray medir during the echo.
    for (int k = 0; k < 6; k++) begin
      measure(int'($urandom_range(1, 800)), 1'($urandom_range(0, 1)));
    end

    // Saturation: 1000 cm worth of echo reads as 999.
    measure(1000 * CPCM, 1'b0);
    measure(int'($urandom_range(8, 200)), 1'b0);

`ifdef HCSR04_TIMEOUT_EN
    begin
      int cnt;
      applyStimulus();
      cnt = 0;
      while (!erro && cnt < TMO + 50) begin
        @(negedge clock);
        cnt++;
      end
      checkOutput("erro_delay", cnt, TMO);
      checkOutput("pronto_with_erro", pronto, 0);
      checkOutput("medida_after_erro", medida, last_medida);
      @(negedge clock);
      checkOutput("erro_width", erro, 0);
      checkOutput("estado_after_erro", db_estado, 0);
    end
`endif

    // Reset in the middle of an echo, with medir toggling while measuring.
    applyStimulus();
    echo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      medir = ~medir;
    end
    reset = 1'b1;
    #1;
    checkOutput("midrst_trigger", trigger, 0);
    checkOutput("midrst_pronto", pronto, 0);
    checkOutput("midrst_erro", erro, 0);
    checkOutput("midrst_medida", medida, 12'h000);
    checkOutput("midrst_estado", db_estado, 0);
    @(negedge clock);
    echo  = 1'b0;
    medir = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("idle_after_rst", db_estado, 0);
    measure(2 * CPCM, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interface_hcsr04.md
# interface_hcsr04

Front-end for the HC-SR04 ultrasonic ranger in the trena datapath. On `medir`, it:
- generates the trigger pulse;
- synchronises and times the echo pulse;
- converts the echo width to whole centimetres as three BCD digits.

The completion strobe `pronto` drives the trena control unit's `pronto_medida` input. The `medida` digits feed the serial character mux (centena/dezena/unidade).

## Interface
Parameters:
- `TRIGGER_CYCLES`, 500: trigger high time in clocks (10 µs @ 50 MHz).
- `CYCLES_PER_CM`, 2941: echo-high clocks per centimetre (58.82 µs @ 50 MHz).
- `TIMEOUT_CYCLES`, 1_500_000: watchdog limit in clocks (30 ms); used only with `HCSR04_TIMEOUT_EN`.

Ports:
- `clock` in 1: system clock, single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `medir` in 1: start request; level sampled only in `inicial`.
- `echo` in 1: sensor echo; asynchronous, synchronised internally.
- `trigger` out 1: sensor trigger pulse.
- `medida` out 12: BCD distance; [11:8] centena, [7:4] dezena, [3:0] unidade.
- `pronto` out 1: one-cycle strobe, new `medida` valid.
- `erro` out 1: one-cycle strobe, watchdog expired.
- `db_estado` out 4: current state code.

## Operation
- Echo passes a 2-FF synchroniser; all logic below uses the synchronised `echo_s`.

State machine (`db_estado` code in parentheses):
- `inicial` (0): `medir`=1 → `preparacao`; otherwise stay.
- `preparacao` (1): clear the divider, BCD accumulator and watchdog → `envia_trigger`.
- `envia_trigger` (2): `trigger`=1 for exactly TRIGGER_CYCLES clocks → `espera_echo`.
- `espera_echo` (3): `echo_s`=1 → `medindo`.
- `medindo` (4): per cycle with `echo_s`=1, the divider increments.
  - At CYCLES_PER_CM-1 the divider wraps to 0 and the BCD accumulator increments.
  - `echo_s`=0 → `armazena`.
- `armazena` (5): `medida` ← accumulator → `final_medida`.
- `final_medida` (6): `pronto`=1 → `inicial`.
- `erro_timeout` (E): `erro`=1 → `inicial`; `medida` unchanged.
- Any unused encoding → `inicial`; `db_estado` reports F.

Arithmetic:
- `medida` = floor(echo_high_cycles / CYCLES_PER_CM), computed in BCD with per-digit carry 9→0.
- Saturates at 12'h999: once 999 is reached, further increments are ignored.

Boundary behaviour:
- `medir` outside `inicial` is ignored; there is no queueing.
- Echo already high on entry to `espera_echo` counts from that cycle.
- Reset at any point returns to `inicial` and forces the reset values below; an in-flight measurement is discarded.

## Timing
Reset values:
- `trigger`=0, `pronto`=0, `erro`=0.
- `medida`=12'h000, `db_estado`=0.

All outputs are registered or Moore-decoded from the state register.

Latency:
- `medir` sampled high at edge k → `trigger` rises at edge k+2 and falls at edge k+2+TRIGGER_CYCLES.
- Echo falling edge at the pin → `pronto` high 4 clocks later (2 sync + `armazena` + `final_medida`).
- `medida` is stable from the cycle `pronto` rises until the next `armazena`.
- `pronto` and `erro` are never high together and are never high for more than one cycle.

## Configuration
With `HCSR04_TIMEOUT_EN` defined:
- A watchdog counts clocks in `espera_echo` plus `medindo`.
- At TIMEOUT_CYCLES the FSM goes to `erro_timeout`.

Without `HCSR04_TIMEOUT_EN`:
- No watchdog is instantiated; `espera_echo` and `medindo` wait indefinitely.
- `erro` is tied 0 and `erro_timeout` is unreachable.

## Structure
- Shared package `trena_pkg`:
  - state encodings;
  - default TRIGGER_CYCLES, CYCLES_PER_CM and TIMEOUT_CYCLES;
  - BCD width constant (12).
- Natural sub-module: `contador_bcd_3dig`, a 3-digit saturating BCD counter with `zera`, `conta` and 12-bit `valor`.
- The clock divider, synchroniser and watchdog stay inline in this module.

## Test plan
- Reset, then `medir` pulse, echo high 147_050 clocks → `trigger` high exactly 500 clocks; `medida`=12'h050; single-cycle `pronto`.
- Echo high 147_049 clocks → `medida`=12'h049 (truncation).
- Echo high 2_941 clocks → 12'h001; a following measurement with echo 0 clocks is impossible, so run echo 2_940 clocks → 12'h000.
- Without `HCSR04_TIMEOUT_EN`, echo high 3_000_000 clocks → `medida`=12'h999 (saturated), `pronto` asserted.
- With `HCSR04_TIMEOUT_EN`, echo never rises → `erro` pulse 1_500_000 clocks after the trigger ends; `medida` keeps its previous value; state returns to 0.
- `medir` toggled during `medindo`, then `reset` mid-echo → start ignored; after reset all outputs at reset values and `db_estado`=0.
